bcm_scheduler: RTL

BCM_SCHEDULER -- requirements
Module: bcm_scheduler

---
 rtl/hub75_pkg.sv | 24 ++
 rtl/oe_timer.sv | 52 +++++
 rtl/bcm_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
//==============================================================================
// Module      : hub75_pkg
// Description : Shared types and default geometry for the HUB75 BCM scan path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package hub75_pkg;

    typedef enum logic [2:0] {
        ST_SHIFT     = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_LATCH     = 3'd2,
        ST_DISPLAY   = 3'd3,
        ST_BLANK     = 3'd4
    } state_t;

    localparam int c_def_rows        = 16;
    localparam int c_def_planes      = 4;
    localparam int c_def_base_cycles = 32;

endpackage

`default_nettype wire

// File: rtl/oe_timer.sv
//==============================================================================
// Module      : oe_timer
// Description : Loadable down-counter timing one DISPLAY period; flags the last
//               cycle and whether the output-enable window is still open.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module oe_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cut_val,
    input  logic             en,
    output logic             tc,
    output logic             on
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] cut_q, cut_d;

    always_comb begin
        count_d = count_q;
        cut_d   = cut_q;
        if (load) begin
            count_d = load_val;
            cut_d   = cut_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            cut_q   <= '0;
        end else begin
            count_q <= count_d;
            cut_q   <= cut_d;
        end
    end

    // Counting down N..1, the window is open while the count is above the cut.
    assign tc = (count_q == WIDTH'(1));
    assign on = (count_q > cut_q);

endmodule

`default_nettype wire

// File: rtl/bcm_scheduler.sv
//==============================================================================
// Module      : bcm_scheduler
// Description : Binary-code-modulation row/plane scheduler for HUB75 panels with
//               frame-synchronous buffer swap. Optional global dimming is built
//               in when BCM_BRIGHTNESS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcm_scheduler
    import hub75_pkg::*;
#(
    parameter int BASE_CYCLES = c_def_base_cycles,
    parameter int ROWS        = c_def_rows,
    parameter int PLANES      = c_def_planes
) (
    input  logic                                        clk,
    input  logic                                        reset,
    output logic                                        shift_start,
    input  logic                                        shift_done,
    output logic [$clog2(ROWS)-1:0]                     row,
    output logic [((PLANES > 1) ? $clog2(PLANES) : 1)-1:0] plane,
    output logic                                        latch,
    output logic                                        oe_n,
    input  logic                                        swap_req,
    output logic                                        swap_ack,
    output logic                                        front_buf
`ifdef BCM_BRIGHTNESS_EN
    ,
    input  logic [7:0]                                  brightness
`endif
);

    localparam int c_row_w   = $clog2(ROWS);
    localparam int c_plane_w = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int c_cnt_w   = $clog2(BASE_CYCLES << (PLANES - 1)) + 1;

    localparam logic [c_row_w-1:0]   c_last_row   = c_row_w'(ROWS - 1);
    localparam logic [c_plane_w-1:0] c_last_plane = c_plane_w'(PLANES - 1);

    state_t               state_q, state_d;
    logic [c_row_w-1:0]   row_q, row_d;
    logic [c_plane_w-1:0] plane_q, plane_d;
    logic                 front_buf_q, front_buf_d;

    logic [c_cnt_w-1:0]   w_disp_len;
    logic [c_cnt_w-1:0]   w_cut_len;
    logic                 w_timer_load;
    logic                 w_timer_en;
    logic                 w_timer_tc;
    logic                 w_timer_on;

    assign w_disp_len = c_cnt_w'(BASE_CYCLES) << plane_q;

`ifdef BCM_BRIGHTNESS_EN
    logic [c_cnt_w-1:0] w_on_len;

    // Lit cycles = floor(len * brightness / 256); dark for the remainder.
    assign w_on_len  = c_cnt_w'(({8'd0, w_disp_len} * {{c_cnt_w{1'b0}}, brightness}) >> 8);
    assign w_cut_len = w_disp_len - w_on_len;
`else
    assign w_cut_len = '0;
`endif

    oe_timer #(
        .WIDTH (c_cnt_w)
    ) u_oe_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_timer_load),
        .load_val (w_disp_len),
        .cut_val  (w_cut_len),
        .en       (w_timer_en),
        .tc       (w_timer_tc),
        .on       (w_timer_on)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        plane_d      = plane_q;
        front_buf_d  = front_buf_q;
        shift_start  = 1'b0;
        latch        = 1'b0;
        oe_n         = 1'b1;
        swap_ack     = 1'b0;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                // Reset parks the FSM in SHIFT; the pulse must stay low until release.
                shift_start = ~reset;
                state_d     = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (shift_done) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                latch        = 1'b1;
                w_timer_load = 1'b1;
                state_d      = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                w_timer_en = 1'b1;
                oe_n       = ~w_timer_on;
                if (w_timer_tc) begin
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                state_d = ST_SHIFT;
                if (plane_q == c_last_plane) begin
                    plane_d = '0;
                    if (row_q == c_last_row) begin
                        row_d = '0;
                        if (swap_req) begin
                            front_buf_d = ~front_buf_q;
                            swap_ack    = 1'b1;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    plane_d = plane_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SHIFT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SHIFT;
            row_q       <= '0;
            plane_q     <= '0;
            front_buf_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            plane_q     <= plane_d;
            front_buf_q <= front_buf_d;
        end
    end

    assign row       = row_q;
    assign plane     = plane_q;
    assign front_buf = front_buf_q;

endmodule

`default_nettype wire
